// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
// The UVM monitor and scoreboard import this package as well.
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

   // Width needed to hold an occupancy count of 0..depth inclusive.
   function automatic int clog2_count(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write port, and a
// read port that is either registered (REG_RD=1) or combinational with hold (REG_RD=0).
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter bit REG_RD = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] data_q;

   // NOTE: the array has no reset so it maps onto RAM; only the output register is reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered mode: rd_en loads the head. Combinational mode: rd_en means
   // "head valid", and data_q keeps the last shown word for when it is not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       data_q <= '0;
      else if (rd_en) data_q <= mem[rd_addr];
   end

   if (REG_RD) begin : g_reg_rd
      assign rd_data = data_q;
   end else begin : g_async_rd
      assign rd_data = rd_en ? mem[rd_addr] : data_q;
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, registered flags
// and one-cycle overflow/underflow pulses around a fifo_mem array.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2,
   parameter bit FWFT     = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             data_in,
   input  logic                          rd_en,
   output logic [DATA_W-1:0]             data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [clog2_count(DEPTH)-1:0] count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = clog2_count(DEPTH);

   if (AE_LEVEL >= AF_LEVEL || DEPTH < 2) begin : g_param_check
      $fatal(1, "sync_fifo_param: need AE_LEVEL < AF_LEVEL and DEPTH >= 2");
   end

   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [CW-1:0] count_nxt;
   logic          wr_acc, rd_acc;
   fifo_status_t  stat_q, stat_nxt;

   // A write to a full FIFO is accepted only when a read frees the head slot.
   assign rd_acc = rd_en & ~stat_q.empty;
   assign wr_acc = wr_en & (~stat_q.full | rd_acc);

   // Explicit wrap so non-power-of-two depths work.
   assign wr_ptr_nxt = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
   assign rd_ptr_nxt = (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
      stat_nxt.full         = (count_nxt == CW'(DEPTH));
      stat_nxt.empty        = (count_nxt == '0);
      stat_nxt.almost_full  = (count_nxt >= CW'(AF_LEVEL));
      stat_nxt.almost_empty = (count_nxt <= CW'(AE_LEVEL));
      stat_nxt.overflow     = wr_en & ~wr_acc;
      stat_nxt.underflow    = rd_en & ~rd_acc;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         stat_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                     almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr_nxt;
         if (rd_acc) rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         stat_q <= stat_nxt;
      end
   end

   assign full         = stat_q.full;
   assign empty        = stat_q.empty;
   assign almost_full  = stat_q.almost_full;
   assign almost_empty = stat_q.almost_empty;
   assign overflow     = stat_q.overflow;
   assign underflow    = stat_q.underflow;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .REG_RD (!FWFT)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_en   (FWFT ? ~stat_q.empty : rd_acc),
      .rd_addr (rd_ptr),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a DEPTH=16 standard-read FIFO and a DEPTH=5 first-word-fall-through FIFO.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;

   logic       s_wr, s_rd, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
   logic [7:0] s_din, s_dout;
   logic [4:0] s_count;

   logic       f_wr, f_rd, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
   logic [7:0] f_din, f_dout;
   logic [2:0] f_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1'b0)) u_std (
      .clk(clk), .rst(rst), .wr_en(s_wr), .data_in(s_din), .rd_en(s_rd), .data_out(s_dout),
      .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .count(s_count), .overflow(s_ovf), .underflow(s_unf));

   sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) u_ff (
      .clk(clk), .rst(rst), .wr_en(f_wr), .data_in(f_din), .rd_en(f_rd), .data_out(f_dout),
      .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .overflow(f_ovf), .underflow(f_unf));

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
      f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      repeat (3) step();
      n_tests++; if ({s_empty, s_ae, s_full, s_af} !== 4'b1100) begin n_fail++; $display("FAIL reset_std_flags got %b exp 1100", {s_empty, s_ae, s_full, s_af}); end
      n_tests++; if (s_count !== 5'd0) begin n_fail++; $display("FAIL reset_std_count got %0d exp 0", s_count); end
      n_tests++; if (s_dout !== 8'h00) begin n_fail++; $display("FAIL reset_std_dout got %h exp 00", s_dout); end
      n_tests++; if ({s_ovf, s_unf} !== 2'b00) begin n_fail++; $display("FAIL reset_std_pulses got %b exp 00", {s_ovf, s_unf}); end
      n_tests++; if ({f_empty, f_ae, f_full, f_af, f_count, f_dout} !== {4'b1100, 3'd0, 8'h00}) begin n_fail++; $display("FAIL reset_ff got %b exp 1100_000_00000000", {f_empty, f_ae, f_full, f_af, f_count, f_dout}); end
      @(negedge clk);
      rst = 1'b1;
      step();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) begin
         s_wr = 1'b1; s_din = 8'(i);
         step();
         n_tests++; if (s_count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, s_count, i + 1); end
         n_tests++; if (s_af !== (i + 1 >= 14)) begin n_fail++; $display("FAIL fill_af[%0d] got %b exp %b", i, s_af, (i + 1 >= 14)); end
         n_tests++; if (s_full !== (i + 1 == 16)) begin n_fail++; $display("FAIL fill_full[%0d] got %b exp %b", i, s_full, (i + 1 == 16)); end
      end
      s_din = 8'hEE;
      step();
      n_tests++; if ({s_ovf, s_count} !== {1'b1, 5'd16}) begin n_fail++; $display("FAIL overflow_pulse got ovf=%b count=%0d exp ovf=1 count=16", s_ovf, s_count); end
      s_wr = 1'b0;
      step();
      n_tests++; if ({s_ovf, s_count} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL overflow_clear got ovf=%b count=%0d exp ovf=0 count=16", s_ovf, s_count); end
      for (int i = 0; i < 16; i++) begin
         s_rd = 1'b1;
         step();
         n_tests++; if (s_dout !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, s_dout, 8'(i)); end
         n_tests++; if (s_count !== 5'(15 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, s_count, 15 - i); end
         n_tests++; if ({s_empty, s_ae} !== {(i == 15), (15 - i <= 2)}) begin n_fail++; $display("FAIL drain_flags[%0d] got %b exp %b", i, {s_empty, s_ae}, {(i == 15), (15 - i <= 2)}); end
      end
      step();
      n_tests++; if ({s_unf, s_dout} !== {1'b1, 8'h0F}) begin n_fail++; $display("FAIL underflow_pulse got unf=%b dout=%h exp unf=1 dout=0f", s_unf, s_dout); end
      s_rd = 1'b0;
      step();
      n_tests++; if (s_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear got %b exp 0", s_unf); end
   endtask

   task automatic test_full_wr_rd();
      for (int i = 0; i < 16; i++) begin
         s_wr = 1'b1; s_din = 8'(8'h10 + i);
         step();
      end
      s_rd = 1'b1; s_din = 8'hAA;
      step();
      n_tests++; if ({s_count, s_ovf, s_full} !== {5'd16, 1'b0, 1'b1}) begin n_fail++; $display("FAIL full_wr_rd got count=%0d ovf=%b full=%b exp count=16 ovf=0 full=1", s_count, s_ovf, s_full); end
      n_tests++; if (s_dout !== 8'h10) begin n_fail++; $display("FAIL full_wr_rd_head got %h exp 10", s_dout); end
      s_wr = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         step();
         n_tests++; if (s_dout !== ((i == 16) ? 8'hAA : 8'(8'h10 + i))) begin n_fail++; $display("FAIL full_wr_rd_drain[%0d] got %h exp %h", i, s_dout, (i == 16) ? 8'hAA : 8'(8'h10 + i)); end
      end
      n_tests++; if (s_empty !== 1'b1) begin n_fail++; $display("FAIL full_wr_rd_empty got %b exp 1", s_empty); end
      s_rd = 1'b0;
      step();
   endtask

   task automatic test_empty_wr_rd();
      s_wr = 1'b1; s_rd = 1'b1; s_din = 8'h55;
      f_wr = 1'b1; f_rd = 1'b1; f_din = 8'h55;
      step();
      n_tests++; if ({s_unf, s_count, s_empty} !== {1'b1, 5'd1, 1'b0}) begin n_fail++; $display("FAIL empty_wr_rd_std got unf=%b count=%0d empty=%b exp 1/1/0", s_unf, s_count, s_empty); end
      n_tests++; if ({f_unf, f_count, f_empty} !== {1'b1, 3'd1, 1'b0}) begin n_fail++; $display("FAIL empty_wr_rd_ff got unf=%b count=%0d empty=%b exp 1/1/0", f_unf, f_count, f_empty); end
      n_tests++; if (f_dout !== 8'h55) begin n_fail++; $display("FAIL fwft_show got %h exp 55", f_dout); end
      idle();
      step();
      n_tests++; if ({s_unf, f_unf, f_dout} !== {2'b00, 8'h55}) begin n_fail++; $display("FAIL empty_wr_rd_after got %b_%h exp 00_55", {s_unf, f_unf}, f_dout); end
      s_rd = 1'b1; f_rd = 1'b1;
      step();
      n_tests++; if ({s_dout, s_empty} !== {8'h55, 1'b1}) begin n_fail++; $display("FAIL std_pop got %h/%b exp 55/1", s_dout, s_empty); end
      n_tests++; if ({f_dout, f_empty, f_unf} !== {8'h55, 1'b1, 1'b0}) begin n_fail++; $display("FAIL fwft_pop_hold got %h/%b/%b exp 55/1/0", f_dout, f_empty, f_unf); end
      idle();
      step();
   endtask

   task automatic test_wrap();
      f_wr = 1'b1; f_din = 8'h30;
      step();
      f_din = 8'h31;
      step();
      for (int k = 0; k < 12; k++) begin
         n_tests++; if ({f_dout, f_count} !== {8'(8'h30 + k), 3'd2}) begin n_fail++; $display("FAIL wrap_head[%0d] got %h/%0d exp %h/2", k, f_dout, f_count, 8'(8'h30 + k)); end
         f_wr = 1'b1; f_rd = 1'b1; f_din = 8'(8'h32 + k);
         step();
      end
      n_tests++; if ({f_af, f_ae, f_full, f_empty} !== 4'b0000) begin n_fail++; $display("FAIL wrap_flags got %b exp 0000", {f_af, f_ae, f_full, f_empty}); end
      f_wr = 1'b0; f_rd = 1'b0;
      step();
      n_tests++; if (f_dout !== 8'h3C) begin n_fail++; $display("FAIL wrap_tail0 got %h exp 3c", f_dout); end
      f_rd = 1'b1;
      step();
      n_tests++; if ({f_dout, f_ae} !== {8'h3D, 1'b1}) begin n_fail++; $display("FAIL wrap_tail1 got %h/%b exp 3d/1", f_dout, f_ae); end
      step();
      n_tests++; if ({f_dout, f_empty} !== {8'h3D, 1'b1}) begin n_fail++; $display("FAIL wrap_empty got %h/%b exp 3d/1", f_dout, f_empty); end
      idle();
      step();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 7; i++) begin
         s_wr = 1'b1; s_din = 8'(8'h60 + i);
         f_wr = 1'b1; f_din = 8'(8'h70 + i);
         step();
      end
      n_tests++; if (s_count !== 5'd7) begin n_fail++; $display("FAIL pre_reset_count got %0d exp 7", s_count); end
      #2 rst = 1'b0;
      #1;
      n_tests++; if ({s_count, s_empty, s_full, s_ovf, s_unf} !== {5'd0, 4'b1000}) begin n_fail++; $display("FAIL async_reset_std got count=%0d flags=%b exp 0/1000", s_count, {s_empty, s_full, s_ovf, s_unf}); end
      n_tests++; if ({f_count, f_empty, f_full, f_ovf, f_unf} !== {3'd0, 4'b1000}) begin n_fail++; $display("FAIL async_reset_ff got count=%0d flags=%b exp 0/1000", f_count, {f_empty, f_full, f_ovf, f_unf}); end
      idle();
      step();
      @(negedge clk);
      rst = 1'b1;
      s_rd = 1'b1;
      step();
      n_tests++; if ({s_unf, s_empty, s_count, s_dout} !== {2'b11, 5'd0, 8'h00}) begin n_fail++; $display("FAIL post_reset_read got unf=%b empty=%b count=%0d dout=%h exp 1/1/0/00", s_unf, s_empty, s_count, s_dout); end
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_wr_rd();
      test_empty_wr_rd();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
